// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the write-back engine state type.
package axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_ADDR,
      WB_DATA,
      WB_RESP
   } wb_state_t;

endpackage

// File: rtl/axi_line_writer.sv
// Data-cache write-back engine: one dirty line out as a single AXI4 INCR write burst.
module axi_line_writer
   import axi_pkg::*;
#(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned BEATS  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_req_valid,
   output logic                     wb_req_ready,
   input  logic [ADDR_W-1:0]        wb_addr,
   input  logic [BEATS*DATA_W-1:0]  wb_line,
   output logic                     wb_done,
   output logic                     wb_error,
   output logic                     m_axi_awvalid,
   input  logic                     m_axi_awready,
   output logic [ADDR_W-1:0]        m_axi_awaddr,
   output logic [7:0]               m_axi_awlen,
   output logic [2:0]               m_axi_awsize,
   output logic [1:0]               m_axi_awburst,
   output logic                     m_axi_wvalid,
   input  logic                     m_axi_wready,
   output logic [DATA_W-1:0]        m_axi_wdata,
   output logic [DATA_W/8-1:0]      m_axi_wstrb,
   output logic                     m_axi_wlast,
   input  logic                     m_axi_bvalid,
   output logic                     m_axi_bready,
   input  logic [1:0]               m_axi_bresp
);

   localparam int unsigned CNT_W  = $clog2(BEATS);
   localparam int unsigned OFF_W  = $clog2((BEATS * DATA_W) / 8);
   localparam int unsigned STRB_W = DATA_W / 8;

   wb_state_t                       state_q;
   logic [CNT_W-1:0]                cnt_q;
   logic [CNT_W-1:0]                cnt_d;
   logic [BEATS-1:0][DATA_W-1:0]    line_q;
   logic                            req_ready_q;
   logic                            done_q;
   logic                            error_q;
   logic                            awvalid_q;
   logic [ADDR_W-1:0]               awaddr_q;
   logic                            wvalid_q;
   logic [DATA_W-1:0]               wdata_q;
   logic [STRB_W-1:0]               wstrb_q;
   logic                            wlast_q;
   logic                            bready_q;
   logic                            addr_offset_unused;

   // Line-offset address bits are forced to zero in the burst address.
   assign addr_offset_unused = ^wb_addr[OFF_W-1:0];

   // Index of the beat that follows the one currently on the W channel.
   assign cnt_d = cnt_q + CNT_W'(1);

   // Write-back FSM: capture line, AW, W beats, B response, done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= WB_IDLE;
         cnt_q       <= '0;
         line_q      <= '0;
         req_ready_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         awvalid_q   <= 1'b0;
         awaddr_q    <= '0;
         wvalid_q    <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         wlast_q     <= 1'b0;
         bready_q    <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            WB_IDLE: begin
               // Ready comes back one cycle after the done pulse.
               req_ready_q <= 1'b1;
               if (req_ready_q && wb_req_valid) begin
                  req_ready_q <= 1'b0;
                  awaddr_q    <= {wb_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                  line_q      <= wb_line;
                  awvalid_q   <= 1'b1;
                  state_q     <= WB_ADDR;
               end
            end
            WB_ADDR: begin
               if (m_axi_awready) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b1;
                  wstrb_q   <= '1;
                  wdata_q   <= line_q[0];
                  wlast_q   <= (BEATS == 1);
                  cnt_q     <= '0;
                  state_q   <= WB_DATA;
               end
            end
            WB_DATA: begin
               if (m_axi_wready) begin
                  if (wlast_q) begin
                     wvalid_q <= 1'b0;
                     wstrb_q  <= '0;
                     wlast_q  <= 1'b0;
                     cnt_q    <= '0;
                     bready_q <= 1'b1;
                     state_q  <= WB_RESP;
                  end else begin
                     cnt_q   <= cnt_d;
                     wdata_q <= line_q[cnt_d];
                     wlast_q <= (cnt_d == CNT_W'(BEATS - 1));
                  end
               end
            end
            WB_RESP: begin
               if (m_axi_bvalid) begin
                  bready_q <= 1'b0;
                  done_q   <= 1'b1;
                  error_q  <= (m_axi_bresp != AXI_RESP_OKAY);
                  state_q  <= WB_IDLE;
               end
            end
            default: begin
               state_q <= WB_IDLE;
            end
         endcase
      end
   end

   assign wb_req_ready  = req_ready_q;
   assign wb_done       = done_q;
   assign wb_error      = error_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awlen   = 8'(BEATS - 1);
   assign m_axi_awsize  = AXI_SIZE_8B;
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wlast   = wlast_q;
   assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_line_writer.sv
// Randomized self-checking bench for axi_line_writer with a transaction-level model.
module tb_axi_line_writer;

   logic         clk = 1'b0;
   logic         reset;
   logic         wb_req_valid;
   logic         wb_req_ready;
   logic [63:0]  wb_addr;
   logic [511:0] wb_line;
   logic         wb_done;
   logic         wb_error;
   logic         m_axi_awvalid;
   logic         m_axi_awready;
   logic [63:0]  m_axi_awaddr;
   logic [7:0]   m_axi_awlen;
   logic [2:0]   m_axi_awsize;
   logic [1:0]   m_axi_awburst;
   logic         m_axi_wvalid;
   logic         m_axi_wready;
   logic [63:0]  m_axi_wdata;
   logic [7:0]   m_axi_wstrb;
   logic         m_axi_wlast;
   logic         m_axi_bvalid;
   logic         m_axi_bready;
   logic [1:0]   m_axi_bresp;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   axi_line_writer dut (
      .clk           (clk),
      .reset         (reset),
      .wb_req_valid  (wb_req_valid),
      .wb_req_ready  (wb_req_ready),
      .wb_addr       (wb_addr),
      .wb_line       (wb_line),
      .wb_done       (wb_done),
      .wb_error      (wb_error),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awlen   (m_axi_awlen),
      .m_axi_awsize  (m_axi_awsize),
      .m_axi_awburst (m_axi_awburst),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wlast   (m_axi_wlast),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_bresp   (m_axi_bresp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Transaction-level model: phase 0 idle, 1 address, 2 data, 3 response.
   int          m_phase = 0;
   int          m_beat  = 0;
   bit          m_ready = 1'b1;
   bit          m_done  = 1'b0;
   bit          m_err   = 1'b0;
   logic [63:0] m_addr  = '0;
   logic [63:0] m_beats [8];

   always @(posedge clk) begin
      if (reset) begin
         m_phase = 0;
         m_beat  = 0;
         m_ready = 1'b1;
         m_done  = 1'b0;
         m_err   = 1'b0;
      end else begin
         m_done = 1'b0;
         m_err  = 1'b0;
         case (m_phase)
            0: begin
               if (m_ready && wb_req_valid) begin
                  m_addr = wb_addr & ~64'h3f;
                  for (int k = 0; k < 8; k++) m_beats[k] = wb_line[64*k +: 64];
                  m_phase = 1;
                  m_ready = 1'b0;
               end else begin
                  m_ready = 1'b1;
               end
            end
            1: if (m_axi_awready) begin
               m_phase = 2;
               m_beat  = 0;
            end
            2: if (m_axi_wready) begin
               m_beat++;
               if (m_beat == 8) m_phase = 3;
            end
            default: if (m_axi_bvalid) begin
               m_done  = 1'b1;
               m_err   = (m_axi_bresp != 2'b00);
               m_phase = 0;
               m_ready = 1'b0;
            end
         endcase
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("awvalid", m_axi_awvalid, m_phase == 1);
         if (m_phase == 1) begin
            chk("awaddr", m_axi_awaddr, m_addr);
            chk("awlen", m_axi_awlen, 7);
            chk("awsize", m_axi_awsize, 3);
            chk("awburst", m_axi_awburst, 1);
         end
         chk("wvalid", m_axi_wvalid, m_phase == 2);
         chk("wstrb", m_axi_wstrb, (m_phase == 2) ? 8'hff : 8'h00);
         chk("wlast", m_axi_wlast, (m_phase == 2) && (m_beat == 7));
         if (m_phase == 2) chk("wdata", m_axi_wdata, m_beats[m_beat]);
         chk("bready", m_axi_bready, m_phase == 3);
         chk("wb_done", wb_done, m_done);
         chk("wb_error", wb_error, m_err);
         chk("wb_req_ready", wb_req_ready, m_ready);
      end
   end

   // Handshake logs: W beats as {wlast, wdata}, AW addresses.
   logic [64:0] wlog [$];
   logic [63:0] awlog [$];

   always @(posedge clk) begin
      if (!reset && m_axi_wvalid && m_axi_wready) wlog.push_back({m_axi_wlast, m_axi_wdata});
      if (!reset && m_axi_awvalid && m_axi_awready) awlog.push_back(m_axi_awaddr);
   end

   function automatic logic [511:0] rand_line();
      logic [511:0] l;
      for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom();
      return l;
   endfunction

   // Drive slave-side readies for the coming cycle according to the mode.
   task automatic drive_readies(input int mode, inout int aw_hold, inout bit wr_tog);
      m_axi_bvalid = 1'b1;
      m_axi_awready = 1'b1;
      m_axi_wready = 1'b1;
      case (mode)
         1: if (m_axi_awvalid && aw_hold < 5) begin
            m_axi_awready = 1'b0;
            aw_hold++;
         end
         2: begin
            wr_tog = ~wr_tog;
            m_axi_wready = wr_tog;
         end
         3: begin
            m_axi_awready = 1'($urandom_range(0, 1));
            m_axi_wready  = 1'($urandom_range(0, 1));
            m_axi_bvalid  = 1'($urandom_range(0, 1));
         end
         default: ;
      endcase
   endtask

   // mode: 0 all ready, 1 AW stalled 5 cycles, 2 wready toggling, 3 random.
   task automatic run_txn(input logic [63:0] addr, input logic [511:0] line, input int mode,
                          input logic [1:0] resp, input int rst_beat);
      int w_base  = wlog.size();
      int aw_base = awlog.size();
      int acc_n   = -1;
      int done_n  = -1;
      int aw_vis  = 0;
      int aw_hold = 0;
      bit wr_tog  = 1'b0;
      bit done_seen = 1'b0;
      bit err_seen  = 1'b0;
      bit late_done = 1'b0;
      wb_req_valid = 1'b1;
      wb_addr      = addr;
      wb_line      = line;
      m_axi_bresp  = resp;
      drive_readies(mode, aw_hold, wr_tog);
      for (int n = 0; n < 400 && !done_seen; n++) begin
         @(posedge clk);
         #1;
         if (m_axi_awvalid) begin
            aw_vis++;
            if (acc_n < 0) begin
               acc_n        = n;
               wb_req_valid = 1'b0;
               wb_addr      = {$urandom(), $urandom()};
               wb_line      = rand_line();
            end
         end
         if (wb_done) begin
            done_seen = 1'b1;
            done_n    = n;
            err_seen  = wb_error;
         end
         if (rst_beat >= 0 && (wlog.size() - w_base) == rst_beat) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            chk("rst_wvalid", m_axi_wvalid, 0);
            chk("rst_ready", wb_req_ready, 1);
            chk("rst_awvalid", m_axi_awvalid, 0);
            for (int j = 0; j < 15; j++) begin
               if (wb_done) late_done = 1'b1;
               @(posedge clk);
               #1;
            end
            chk("rst_no_done", late_done, 0);
            return;
         end
         drive_readies(mode, aw_hold, wr_tog);
      end
      chk("done_seen", done_seen, 1);
      chk("done_error", err_seen, resp != 2'b00);
      chk("aw_count", awlog.size() - aw_base, 1);
      if (awlog.size() > aw_base) chk("aw_addr_log", awlog[aw_base], addr & ~64'h3f);
      chk("w_count", wlog.size() - w_base, 8);
      for (int k = 0; k < 8 && (w_base + k) < wlog.size(); k++) begin
         chk("beat_data", wlog[w_base + k][63:0], line[64*k +: 64]);
         chk("beat_last", wlog[w_base + k][64], k == 7);
      end
      if (mode == 0) begin
         // Cycles from acceptance through the end of the wb_done cycle.
         chk("latency", done_n - acc_n + 1, 11);
      end
      if (mode == 1) chk("aw_cycles", aw_vis, 6);
      @(posedge clk);
      #1;
      chk("done_pulse_len", wb_done, 0);
      chk("ready_after_done", wb_req_ready, 1);
   endtask

   initial begin
      logic [511:0] l1;
      reset         = 1'b1;
      wb_req_valid  = 1'b0;
      wb_addr       = '0;
      wb_line       = '0;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = 2'b00;
      repeat (2) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_awaddr", m_axi_awaddr, 0);
      chk("reset_wdata", m_axi_wdata, 0);
      chk("reset_wstrb", m_axi_wstrb, 0);
      chk("reset_ready", wb_req_ready, 1);
      chk("reset_done", wb_done, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int k = 0; k < 8; k++) l1[64*k +: 64] = 64'(17 * (k + 1));
      run_txn(64'h8000_1234, l1, 0, 2'b00, -1);
      chk("pin_awaddr", awlog[0], 64'h8000_1200);
      chk("pin_last_beat", wlog[7], {1'b1, 64'h88});
      run_txn({$urandom(), $urandom()}, rand_line(), 1, 2'b00, -1);
      run_txn({$urandom(), $urandom()}, rand_line(), 2, 2'b00, -1);
      run_txn({$urandom(), $urandom()}, rand_line(), 0, 2'b10, -1);
      run_txn({$urandom(), $urandom()}, rand_line(), 0, 2'b00, 4);
      run_txn(64'h0000_0000_dead_beff, rand_line(), 0, 2'b00, -1);
      for (int t = 0; t < 25; t++) begin
         run_txn({$urandom(), $urandom()}, rand_line(), 3, 2'($urandom_range(0, 3)), -1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation ran past %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
